// File: rtl/led_button_and_cascade.sv
// rtl/led_button_and_cascade.sv - pipelined AND-reduction of a button vector to one LED bit
// Optional feature macro: LED_BUTTON_STICKY_EN (adds latched out_sticky output)
module led_button_and_cascade #(
  parameter int LENGTH    = 8,
  parameter int PIPELINED = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LENGTH-1:0] in,
  output logic              out,
  output logic              out_valid
`ifdef LED_BUTTON_STICKY_EN
  ,
  output logic              out_sticky
`endif
);

  // Width of the operand vector entering level lvl (level 0 is the input register).
  function automatic int width_at(input int lvl);
    int w;
    w = LENGTH;
    for (int i = 0; i < lvl; i++) begin
      w = (w + 1) / 2;
    end
    return w;
  endfunction

  // Bit offset of level lvl inside the flattened level bus.
  function automatic int offset_at(input int lvl);
    int o;
    o = 0;
    for (int i = 0; i < lvl; i++) begin
      o = o + width_at(i);
    end
    return o;
  endfunction

  localparam int L     = (LENGTH > 1) ? $clog2(LENGTH) : 0;
  localparam int LAT   = (PIPELINED != 0) ? L + 1 : 2;
  localparam int TOTAL = offset_at(L + 1);
  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [LENGTH-1:0] in_q;
  logic [TOTAL-1:0]  bus;
  logic              tree_out;
  logic [3:0]        fill;

  // Stage 0: capture the input word every cycle, no handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q <= '0;
    end else begin
      in_q <= in;
    end
  end

  assign bus[LENGTH-1:0] = in_q;

  genvar l;
  generate
    for (l = 1; l <= L; l++) begin : g_lvl
      localparam int WI = width_at(l - 1);
      localparam int WO = width_at(l);
      localparam int OI = offset_at(l - 1);
      localparam int OO = offset_at(l);

      logic [WI-1:0]   src;
      logic [2*WO-1:0] pad;
      logic [WO-1:0]   res;

      assign src = bus[OI+WI-1:OI];

      // An odd leftover operand is paired with a constant 1 so it passes through.
      if (WI % 2 == 1) begin : g_odd
        assign pad = {1'b1, src};
      end else begin : g_even
        assign pad = src;
      end

      // Pairwise AND of adjacent operands for this level.
      always_comb begin
        res = '0;
        for (int k = 0; k < WO; k++) begin
          res[k] = pad[2*k] & pad[2*k+1];
        end
      end

      if (PIPELINED != 0) begin : g_reg
        logic [WO-1:0] q;
        // Level register; cleared by reset so in-flight words are discarded.
        always_ff @(posedge clock) begin
          if (reset) begin
            q <= '0;
          end else begin
            q <= res;
          end
        end
        assign bus[OO+WO-1:OO] = q;
      end else begin : g_comb
        assign bus[OO+WO-1:OO] = res;
      end
    end
  endgenerate

  // The final level is a single bit at the top of the bus.
  assign tree_out = bus[TOTAL-1];

  generate
    if (PIPELINED != 0) begin : g_out_pipe
      assign out = tree_out;
    end else begin : g_out_comb
      logic out_r;
      // Single output register behind the combinational tree.
      always_ff @(posedge clock) begin
        if (reset) begin
          out_r <= 1'b0;
        end else begin
          out_r <= tree_out;
        end
      end
      assign out = out_r;
    end
  endgenerate

  // Fill counter: saturates once the pipeline holds only post-reset words.
  always_ff @(posedge clock) begin
    if (reset) begin
      fill <= 4'd0;
    end else if (fill != LAT_C) begin
      fill <= fill + 4'd1;
    end
  end

  assign out_valid = (fill == LAT_C);

`ifdef LED_BUTTON_STICKY_EN
  // Latch any observed high output until the next reset; reset has priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_sticky <= 1'b0;
    end else if (out) begin
      out_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_led_button_and_cascade.sv
// tb/tb_led_button_and_cascade.sv - scoreboard bench for led_button_and_cascade
module tb_led_button_and_cascade;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in8   = '0;
  logic [4:0] in5   = '0;
  logic [0:0] in1   = '0;

  wire o8p, v8p, o8c, v8c, o5p, v5p, o1p, v1p;
  wire s8p, s8c, s5p, s1p;

  always #5 clock = ~clock;

`ifdef LED_BUTTON_STICKY_EN
  led_button_and_cascade #(.LENGTH(8), .PIPELINED(1)) dut8p (
    .clock(clock), .reset(reset), .in(in8), .out(o8p), .out_valid(v8p), .out_sticky(s8p));
  led_button_and_cascade #(.LENGTH(8), .PIPELINED(0)) dut8c (
    .clock(clock), .reset(reset), .in(in8), .out(o8c), .out_valid(v8c), .out_sticky(s8c));
  led_button_and_cascade #(.LENGTH(5), .PIPELINED(1)) dut5p (
    .clock(clock), .reset(reset), .in(in5), .out(o5p), .out_valid(v5p), .out_sticky(s5p));
  led_button_and_cascade #(.LENGTH(1), .PIPELINED(1)) dut1p (
    .clock(clock), .reset(reset), .in(in1), .out(o1p), .out_valid(v1p), .out_sticky(s1p));
`else
  led_button_and_cascade #(.LENGTH(8), .PIPELINED(1)) dut8p (
    .clock(clock), .reset(reset), .in(in8), .out(o8p), .out_valid(v8p));
  led_button_and_cascade #(.LENGTH(8), .PIPELINED(0)) dut8c (
    .clock(clock), .reset(reset), .in(in8), .out(o8c), .out_valid(v8c));
  led_button_and_cascade #(.LENGTH(5), .PIPELINED(1)) dut5p (
    .clock(clock), .reset(reset), .in(in5), .out(o5p), .out_valid(v5p));
  led_button_and_cascade #(.LENGTH(1), .PIPELINED(1)) dut1p (
    .clock(clock), .reset(reset), .in(in1), .out(o1p), .out_valid(v1p));
  assign s8p = 1'b0;
  assign s8c = 1'b0;
  assign s5p = 1'b0;
  assign s1p = 1'b0;
`endif

  typedef struct packed {
    logic o;
    logic v;
    logic s;
  } exp_t;

  // Per-edge history of what the DUTs sampled.
  bit   rst_h[$];
  bit   and_h[3][$];
  exp_t sb[4][$];

  // Instance order: 8 pipelined, 8 combinational, 5 pipelined, 1 pipelined.
  int lat_of[4] = '{4, 2, 4, 1};
  int src_of[4] = '{0, 0, 1, 2};
  bit sticky_m[4];
  bit prev_o[4];

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  // Expected output after the newest recorded edge: the AND of the word sampled
  // lat-1 edges earlier, provided no reset edge fell inside that window.
  function automatic exp_t predict(input int d);
    exp_t e;
    int   n;
    int   m;
    bit   clean;
    e = '0;
    n = rst_h.size() - 1;
    m = n - lat_of[d] + 1;
    if (m < 0) return e;
    clean = 1'b1;
    for (int k = m; k <= n; k++) begin
      if (rst_h[k]) clean = 1'b0;
    end
    if (clean) begin
      e.v = 1'b1;
      e.o = and_h[src_of[d]][m];
    end
    return e;
  endfunction

  task automatic record(input bit r, input logic [7:0] a, input logic [4:0] b);
    exp_t e;
    rst_h.push_back(r);
    and_h[0].push_back(a == 8'hFF);
    and_h[1].push_back(b == 5'h1F);
    and_h[2].push_back(a[0]);
    for (int d = 0; d < 4; d++) begin
      e = predict(d);
      sticky_m[d] = r ? 1'b0 : (sticky_m[d] | prev_o[d]);
      e.s = sticky_m[d];
      prev_o[d] = e.o;
      sb[d].push_back(e);
    end
  endtask

  task automatic step(input bit r, input logic [7:0] a, input logic [4:0] b);
    reset = r;
    in8   = a;
    in5   = b;
    in1   = a[0:0];
    @(posedge clock);
    record(r, a, b);
    #1;
  endtask

  task automatic chk(input string nm, input exp_t e, input logic o, input logic v, input logic s);
    total++;
    if (o !== e.o) begin
      bad++;
      $display("FAIL %s out got=%b exp=%b t=%0t", nm, o, e.o, $time);
    end
    total++;
    if (v !== e.v) begin
      bad++;
      $display("FAIL %s out_valid got=%b exp=%b t=%0t", nm, v, e.v, $time);
    end
`ifdef LED_BUTTON_STICKY_EN
    total++;
    if (s !== e.s) begin
      bad++;
      $display("FAIL %s out_sticky got=%b exp=%b t=%0t", nm, s, e.s, $time);
    end
`else
    if (s !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s sticky tie got=%b exp=0", nm, s);
    end
`endif
  endtask

  // Monitor: each falling edge, pop one prediction per instance and compare.
  always @(negedge clock) begin
    if (!done) begin
      if (sb[0].size() > 0) chk("len8_pipe", sb[0].pop_front(), o8p, v8p, s8p);
      if (sb[1].size() > 0) chk("len8_comb", sb[1].pop_front(), o8c, v8c, s8c);
      if (sb[2].size() > 0) chk("len5_pipe", sb[2].pop_front(), o5p, v5p, s5p);
      if (sb[3].size() > 0) chk("len1_pipe", sb[3].pop_front(), o1p, v1p, s1p);
    end
  end

  initial begin
    logic [7:0] a;
    logic [4:0] b;

    // Reset for two edges.
    step(1'b1, 8'h00, 5'h00);
    step(1'b1, 8'h00, 5'h00);

    // Free-running count, twice through the wrap.
    for (int i = 0; i < 512; i++) begin
      a = 8'(i);
      step(1'b0, a, 5'($urandom));
    end

    // Back-to-back words.
    step(1'b0, 8'hFF, 5'h1F);
    step(1'b0, 8'hFF, 5'h0F);
    step(1'b0, 8'h7F, 5'h1F);
    step(1'b0, 8'hFF, 5'h1E);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 5'h00);

    // Odd width: pass-through operand high vs low.
    step(1'b0, 8'h00, 5'h1F);
    step(1'b0, 8'h00, 5'h00);
    step(1'b0, 8'h00, 5'h0F);
    step(1'b0, 8'h00, 5'h1F);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 5'h00);

    // Reset while an all-ones word is in flight.
    step(1'b0, 8'hFF, 5'h1F);
    step(1'b0, 8'h00, 5'h00);
    step(1'b1, 8'h00, 5'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 8'hFF, 5'h1F);

    // Randomized traffic with biased all-ones words and rare resets.
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
      step(($urandom_range(0, 99) == 0), a, b);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 5'h00);

    @(negedge clock);
    @(negedge clock);
    done = 1'b1;
    total++;
    if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d exp=0",
               sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
